// File: rtl/encodehigh_if.sv
// encodehigh_if: request/handshake bundle for the 4-to-2 priority encoder.
//   d0..d3 : active-high request lines (levels, rising edge = request)
//   ready  : consumer accepts the presented code
//   s0, s1 : registered code bits
//   valid  : {s1,s0} holds an unaccepted code
//   pend   : pending-event register, bit i belongs to di
//   ovf    : sticky overflow flag
// master = request source / code consumer, slave = the encoder.
interface encodehigh_if;
    logic       d0;
    logic       d1;
    logic       d2;
    logic       d3;
    logic       ready;
    logic       s0;
    logic       s1;
    logic       valid;
    logic [3:0] pend;
    logic       ovf;

    modport master (
        output d0, d1, d2, d3, ready,
        input  s0, s1, valid, pend, ovf
    );

    modport slave (
        input  d0, d1, d2, d3, ready,
        output s0, s1, valid, pend, ovf
    );
endinterface

// File: rtl/encodehigh.sv
// encodehigh: sequential 4-to-2 active-high priority encoder.
// Rising edges on d0..d3 become 2-bit codes {s1,s0}, highest line first,
// one pending event queued per line, presented on a valid/ready handshake.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : encodehigh_if.slave (d0..d3, ready in; s0, s1, valid, pend, ovf out)
module encodehigh (
    input  logic         clk,
    input  logic         rst,
    encodehigh_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] d, dq, r, e;
    logic [3:0] pend_q, pend_d, sel_mask;
    logic [1:0] code_q, code_d, sel_idx;
    logic       ovf_q, ovf_d;
    logic       take, load;

    assign d = {bus.d3, bus.d2, bus.d1, bus.d0};

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        sel_mask = '0;
        r        = d & ~dq;
        e        = pend_q | r;
        // Default: new events simply join the pending set.
        pend_d   = pend_q | r;

        casez (e)
            4'b1???: sel_idx = 2'd3;
            4'b01??: sel_idx = 2'd2;
            4'b001?: sel_idx = 2'd1;
            default: sel_idx = 2'd0;
        endcase
        sel_mask[sel_idx] = 1'b1;

        // A new code may be loaded when nothing is held or the held one is accepted.
        take = (state_q == IDLE) || bus.ready;
        if (take) begin
            if (e != 4'b0000) begin
                state_d = HOLD;
                code_d  = sel_idx;
                pend_d  = e & ~sel_mask;
                load    = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        // Event lost: line already pending and not being consumed at this edge.
        if ((r & pend_q & ~(load ? sel_mask : 4'b0000)) != 4'b0000)
            ovf_d = 1'b1;
        // Held line fires again before its code was taken; event is kept in pend.
        if (state_q == HOLD && !bus.ready && r[code_q])
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            pend_q  <= 4'b0000;
            ovf_q   <= 1'b0;
            dq      <= 4'b0000;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            dq      <= d;
        end
    end

    assign bus.s0    = code_q[0];
    assign bus.s1    = code_q[1];
    assign bus.valid = (state_q == HOLD);
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_encodehigh.sv
module tb_encodehigh;
    logic clk = 1'b0;
    logic rst = 1'b1;

    encodehigh_if bus_if ();

    encodehigh dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic       rdy;
        logic       v;
        logic [1:0] c;
        logic [3:0] p;
        logic       o;
    } vec_t;

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [3:0] p;
        logic       o;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [3:0] d, input logic rdy,
                       input logic v, input logic [1:0] c, input logic [3:0] p,
                       input logic o);
        vec_t x;
        x.rst = r; x.d = d; x.rdy = rdy; x.v = v; x.c = c; x.p = p; x.o = o;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [3:0] d, input logic rdy);
        rst          = r;
        bus_if.d0    = d[0];
        bus_if.d1    = d[1];
        bus_if.d2    = d[2];
        bus_if.d3    = d[3];
        bus_if.ready = rdy;
    endtask

    task automatic check_out(input int idx);
        exp_t e;
        logic [1:0] code;
        e = sb.pop_front();
        code = {bus_if.s1, bus_if.s0};
        checks++;
        if (bus_if.valid !== e.v || code !== e.c || bus_if.pend !== e.p || bus_if.ovf !== e.o) begin
            failures++;
            $display("FAIL vec%0d: got valid=%b code=%b pend=%b ovf=%b, want valid=%b code=%b pend=%b ovf=%b",
                     idx, bus_if.valid, code, bus_if.pend, bus_if.ovf, e.v, e.c, e.p, e.o);
        end
    endtask

    initial begin
        exp_t e;
        int   lat;
        drive(1'b1, 4'b0000, 1'b0);

        // rst d rdy | valid code pend ovf (state after the edge)
        // reset, then single d2 pulse
        add(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0100, 1, 1, 2'b10, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0);
        // simultaneous rise, drain 3,2,1,0
        add(0, 4'b1111, 1, 1, 2'b11, 4'b0111, 0);
        add(0, 4'b1111, 1, 1, 2'b10, 4'b0011, 0);
        add(0, 4'b0000, 1, 1, 2'b01, 4'b0001, 0);
        add(0, 4'b0000, 1, 1, 2'b00, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0);
        // backpressure: d1 then d3, then release ready
        add(0, 4'b0010, 0, 1, 2'b01, 4'b0000, 0);
        add(0, 4'b0000, 0, 1, 2'b01, 4'b0000, 0);
        add(0, 4'b1000, 0, 1, 2'b01, 4'b1000, 0);
        add(0, 4'b0000, 0, 1, 2'b01, 4'b1000, 0);
        add(0, 4'b0000, 1, 1, 2'b11, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b11, 4'b0000, 0);
        // d0 held high 5 cycles: exactly one code
        add(0, 4'b0001, 1, 1, 2'b00, 4'b0000, 0);
        add(0, 4'b0001, 1, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0001, 1, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0001, 1, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0001, 1, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b00, 4'b0000, 0);
        // overflow: code 10 held, d1 twice, then d2 re-queued
        add(0, 4'b0100, 0, 1, 2'b10, 4'b0000, 0);
        add(0, 4'b0000, 0, 1, 2'b10, 4'b0000, 0);
        add(0, 4'b0010, 0, 1, 2'b10, 4'b0010, 0);
        add(0, 4'b0000, 0, 1, 2'b10, 4'b0010, 0);
        add(0, 4'b0010, 0, 1, 2'b10, 4'b0010, 1);
        add(0, 4'b0000, 0, 1, 2'b10, 4'b0010, 1);
        add(0, 4'b0100, 0, 1, 2'b10, 4'b0110, 1);
        add(0, 4'b0000, 0, 1, 2'b10, 4'b0110, 1);
        // drain the re-queued d2, then d1
        add(0, 4'b0000, 1, 1, 2'b10, 4'b0010, 1);
        add(0, 4'b0000, 1, 1, 2'b01, 4'b0000, 1);
        // code 01 held, pend 1100, reset with d3 kept high
        add(0, 4'b1100, 0, 1, 2'b01, 4'b1100, 1);
        add(1, 4'b1000, 0, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b1000, 0, 1, 2'b11, 4'b0000, 0);
        add(0, 4'b1000, 1, 0, 2'b11, 4'b0000, 0);
        add(0, 4'b1000, 1, 0, 2'b11, 4'b0000, 0);
        // accept and new event at the same edge
        add(0, 4'b0001, 0, 1, 2'b00, 4'b0000, 0);
        add(0, 4'b0101, 1, 1, 2'b10, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0);
        // pending line fires again while being selected: no overflow
        add(1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add(0, 4'b0010, 0, 1, 2'b01, 4'b0000, 0);
        add(0, 4'b0100, 0, 1, 2'b01, 4'b0100, 0);
        add(0, 4'b0000, 0, 1, 2'b01, 4'b0100, 0);
        add(0, 4'b0100, 1, 1, 2'b10, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].d, vecs[i].rdy);
            e.v = vecs[i].v; e.c = vecs[i].c; e.p = vecs[i].p; e.o = vecs[i].o;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check_out(i);
        end

        // Latency: idle encoder, d3 pulse must give valid after one edge.
        @(negedge clk);
        drive(1'b0, 4'b1000, 1'b1);
        lat = 0;
        while (bus_if.valid !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 1 || {bus_if.s1, bus_if.s0} !== 2'b11) begin
            failures++;
            $display("FAIL latency: got cycles=%0d code=%b, want cycles=1 code=11",
                     lat, {bus_if.s1, bus_if.s0});
        end
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: got valid=%b, want valid=0", bus_if.valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encodehigh.md
# encodehigh

Sequential 4-to-2 active-high priority encoder: the encode-side counterpart of the team's 2-to-4 active-high decoder (`decodehigh`). It turns rising edges on the active-high lines d0..d3 into 2-bit codes {s1,s0} and queues one pending event per line. It presents codes one at a time on a valid/ready handshake. It sits ahead of any consumer that needs to recover which decoded line fired, including a `decodehigh` loopback.

## Interface

- No parameters. Fixed 4 lines, 2-bit code.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d0, d1, d2, d3  in  1 each  active-high request lines (levels). A request is a 0->1 transition.
- ready  in  1  consumer accepts the current code.
- s0  out  1  code bit 0, registered.
- s1  out  1  code bit 1, registered.
- valid  out  1  {s1,s0} holds an unaccepted code.
- pend  out  4  pending-event register P, bit i corresponds to di.
- ovf  out  1  sticky overflow flag.

## Operation

- Edge detect:
  - dq[3:0] registers the previous {d3..d0}.
  - Event r[i] = di & ~dq[i], evaluated at each clock edge.
- Candidate set: E = P | r.
- Selection is fixed priority, highest index first:
  - d3 -> s1=1, s0=1
  - d2 -> s1=1, s0=0
  - d1 -> s1=0, s0=1
  - d0 -> s1=0, s0=0
- State machine, two states:
  - IDLE (valid=0):
    - If E≠0: load the code of the highest set bit of E, set valid, go to HOLD.
    - Every other bit of E goes into P. The selected bit does not enter P.
    - If E=0: stay in IDLE.
  - HOLD (valid=1):
    - s1, s0 and valid stay stable while ready=0. New events OR into P.
    - At an edge with ready=1 (accept) and E≠0: load the next highest code from E. Stay in HOLD with valid=1 (back-to-back, no bubble). The selected bit leaves P.
    - At an edge with ready=1 and E=0: go to IDLE, valid=0. s1 and s0 keep their last value.
- Overflow:
  - ovf sets when r[i]=1 and the P bit for that line, i.e. pend[i], is already 1 at that edge; the new event is lost.
  - ovf is not set when the bit is being selected at that same edge.
  - ovf also sets when r[i]=1 for the line whose code is currently held and unaccepted, with no accept at that edge. In that case the event is queued in P, not lost.
  - ovf clears only on rst.
- The held code's own line may be re-queued: a new rising edge on that line while in HOLD sets its P bit.

## Timing

- Reset values: s0=0, s1=0, valid=0, pend=0, ovf=0, dq=0, state=IDLE.
- Because dq resets to 0, a line held high through reset produces an event at the first edge after rst deasserts.
- Latency: a rising edge of di sampled at edge k gives valid=1 with its code after edge k (one cycle), if idle and di is the highest candidate.
- Throughput: with ready tied high, one code per cycle.
- Lines held high generate exactly one event. A new event needs the line to drop for at least one cycle.
- Simultaneous rising edges: all are captured in the same cycle and drain in order 3,2,1,0 on successive accepts.
- Accept and a new event in the same cycle: the event participates in selection at that same edge.
- rst mid-operation (HOLD or P≠0): all pending and held codes are dropped. Outputs take their reset values at that edge. dq clears.
- ready while valid=0 is ignored.

## Test plan

- Reset: hold rst high for 2 cycles with d=0000 -> s1=0, s0=0, valid=0, pend=0000, ovf=0. Release, then pulse d2 for 1 cycle with ready=1 -> after that edge valid=1, s1=1, s0=0; next edge valid=0.
- Simultaneous: d0..d3 rise in the same cycle, ready=1 -> codes 11, 10, 01, 00 on 4 consecutive cycles, pend progresses 0111, 0011, 0001, 0000, then valid=0.
- Backpressure: ready=0, pulse d1 then d3 -> s1=0, s0=1 held with valid=1 and pend=1000. Raise ready -> next code 11 with no bubble, then valid=0.
- Level hold and overflow:
  - Hold d0 high for 5 cycles -> exactly one 00 code.
  - With ready=0 and code 10 held, pulse d1 twice (low between pulses) -> pend=0010 and ovf=1 after the second pulse.
  - A further d2 pulse -> pend=0110 and ovf stays 1.
- Reset mid-operation: code 01 held, pend=1100, assert rst for 1 cycle -> valid=0, pend=0000, ovf=0. With d3 still high -> one event and code 11 after the first edge following reset release.
